// File: rtl/alu_share_arb.sv
// Two requesters share one registered integer ALU through a round-robin arbiter.
// Define ALU_SHARE_ARB_STATS_EN to add the saturating per-requester grant counters.
module alu_share_arb #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][9:0]       req_fun,
  input  logic [1:0][WIDTH-1:0] req_in1,
  input  logic [1:0][WIDTH-1:0] req_in2,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  state_dbg
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [15:0]           gnt_cnt0,
  output logic [15:0]           gnt_cnt1
`endif
);

  // Handshake: a request transfers on req_valid[i] & req_ready[i]; a result
  // transfers on rsp_valid[i] & rsp_ready[i]. Valid never waits on ready.
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e           state;
  logic             owner;
  logic             last_gnt;
  logic             can_accept;
  logic             accept;
  logic             gnt_idx;
  logic [9:0]       op_fun;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             alt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] alu_res;

  assign state_dbg = (state == HOLD);
  assign rsp_valid = (state == HOLD) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  // The held result may be replaced in the same cycle its owner takes it.
  always_comb begin
    can_accept = !rst && ((state == IDLE) || rsp_ready[owner]);
    gnt_idx    = (req_valid == 2'b11) ? ~last_gnt : req_valid[1];
    accept     = can_accept && (req_valid != 2'b00);
    req_ready  = accept ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    op_fun  = req_fun[gnt_idx];
    op_a    = req_in1[gnt_idx];
    op_b    = req_in2[gnt_idx];
    funct3  = op_fun[9:7];
    funct7  = op_fun[6:0];
    alt     = (funct7 == 7'h20);
    shamt   = op_b[4:0];
    alu_res = '0;
    if (funct7 == 7'h00 || (alt && (funct3 == 3'd0 || funct3 == 3'd5))) begin
      case (funct3)
        3'd0: alu_res = alt ? (op_a - op_b) : (op_a + op_b);
        3'd1: alu_res = op_a << shamt;
        3'd2: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        3'd3: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
        3'd4: alu_res = op_a ^ op_b;
        3'd5: alu_res = alt ? WIDTH'($signed(op_a) >>> shamt) : (op_a >> shamt);
        3'd6: alu_res = op_a | op_b;
        3'd7: alu_res = op_a & op_b;
        default: alu_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      rsp_data <= '0;
    end else if (accept) begin
      state    <= HOLD;
      owner    <= gnt_idx;
      last_gnt <= gnt_idx;
      rsp_data <= alu_res;
    end else if (state == HOLD && rsp_ready[owner]) begin
      state    <= IDLE;
    end
  end

`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (accept) begin
      if (!gnt_idx && gnt_cnt0 != 16'hFFFF) gnt_cnt0 <= gnt_cnt0 + 16'd1;
      if (gnt_idx && gnt_cnt1 != 16'hFFFF) gnt_cnt1 <= gnt_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus random traffic against a behavioural model.
// Define ALU_SHARE_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_share_arb;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [1:0]            req_valid = '0;
  logic [1:0]            req_ready;
  logic [1:0][9:0]       req_fun = '0;
  logic [1:0][WIDTH-1:0] req_in1 = '0;
  logic [1:0][WIDTH-1:0] req_in2 = '0;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready = '0;
  logic [WIDTH-1:0]      rsp_data;
  logic                  state_dbg;
`ifdef ALU_SHARE_ARB_STATS_EN
  logic [15:0]           gnt_cnt0;
  logic [15:0]           gnt_cnt1;
`endif

  alu_share_arb #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fun(req_fun), .req_in1(req_in1), .req_in2(req_in2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .state_dbg(state_dbg)
`ifdef ALU_SHARE_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [WIDTH:0] exp_q[$];   // {owner, result}
  logic       mon_en = 1'b0;
  logic       was_rst = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_owner = 1'b0;
  logic       m_last = 1'b1;
  int         m_cnt0 = 0;
  int         m_cnt1 = 0;
  logic [1:0] exp_rv;
  logic [1:0] exp_rdy;
  logic       hs;
  logic       g;
  logic [WIDTH:0] head;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: arithmetic written straight from the operation table.
  function automatic logic [WIDTH-1:0] ref_alu(input logic [9:0] f, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    int unsigned sh;
    logic [WIDTH-1:0] fill;
    logic is_alt;
    sh = int'(b[4:0]);
    is_alt = (f[6:0] == 7'h20);
    if (f[6:0] != 7'h00 && !is_alt) return '0;
    if (is_alt && f[9:7] != 3'd0 && f[9:7] != 3'd5) return '0;
    case (f[9:7])
      3'd0: return is_alt ? a + (~b + 1) : a + b;
      3'd1: return a << sh;
      3'd2: begin
        if (a[WIDTH-1] != b[WIDTH-1]) return a[WIDTH-1] ? 1 : 0;
        return (a < b) ? 1 : 0;
      end
      3'd3: return (a < b) ? 1 : 0;
      3'd4: return a ^ b;
      3'd5: begin
        fill = (is_alt && a[WIDTH-1]) ? ~({WIDTH{1'b1}} >> sh) : '0;
        return (a >> sh) | fill;
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // ---------------- monitor: model + compare, sampled mid-cycle ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      exp_rv = m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
      check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (was_rst) check("rsp_data_after_rst", 64'(rsp_data), 64'd0);
      if (m_busy) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rsp_orphan: response with empty expected queue at %0t", $time);
        end else begin
          head = exp_q[0];
          check("rsp_data", 64'(rsp_data), 64'(head[WIDTH-1:0]));
          check("rsp_owner", 64'(m_owner), 64'(head[WIDTH]));
        end
      end
      hs = m_busy && rsp_ready[m_owner];
      exp_rdy = 2'b00;
      if (!rst && (!m_busy || hs) && req_valid != 2'b00) begin
        g = (req_valid == 2'b11) ? !m_last : req_valid[1];
        exp_rdy = g ? 2'b10 : 2'b01;
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (rst) begin
        m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
        m_cnt0 = 0; m_cnt1 = 0;
        exp_q.delete();
      end else begin
        if (hs) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_busy = 1'b0;
        end
        if (exp_rdy != 2'b00) begin
          g = exp_rdy[1];
          exp_q.push_back({g, ref_alu(req_fun[g], req_in1[g], req_in2[g])});
          m_busy = 1'b1; m_owner = g; m_last = g;
          if (g) m_cnt1 = (m_cnt1 < 65535) ? m_cnt1 + 1 : m_cnt1;
          else   m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
        end
      end
      was_rst = rst;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_fun[i] = {f3, f7};
    req_in1[i] = a;
    req_in2[i] = b;
  endtask

  function automatic logic [WIDTH-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(WIDTH-1){1'b0}}};
      3: return WIDTH'($urandom_range(0, 40));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  function automatic logic [9:0] rand_fun();
    logic [2:0] f3;
    f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: return {f3, 7'h20};
      1: return {f3, 7'($urandom)};
      default: return {f3, 7'h00};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(1);
    rst = 1'b0;

    // Single add on requester 0: 5 + 7.
    rsp_ready = 2'b11;
    set_req(0, 3'd0, 7'h00, 32'd5, 32'd7);
    req_valid = 2'b01;
    step(1);
    req_valid = 2'b00;
    step(2);

    // Requester 1: sub, sra, slt, sltu.
    set_req(1, 3'd0, 7'h20, 32'd3, 32'd5);
    req_valid = 2'b10; step(1);
    set_req(1, 3'd5, 7'h20, 32'h8000_0000, 32'd4); step(1);
    set_req(1, 3'd2, 7'h00, 32'hFFFF_FFFF, 32'd1); step(1);
    set_req(1, 3'd3, 7'h00, 32'hFFFF_FFFF, 32'd1); step(1);
    set_req(1, 3'd1, 7'h20, 32'd9, 32'd1); step(1);
    req_valid = 2'b00;
    step(2);

    // Round robin with both continuously valid after a fresh reset.
    rst = 1'b1; step(1); rst = 1'b0;
    set_req(0, 3'd4, 7'h00, 32'h0F0F_0F0F, 32'h00FF_00FF);
    set_req(1, 3'd6, 7'h00, 32'h1234_0000, 32'h0000_5678);
    req_valid = 2'b11;
    step(6);
    req_valid = 2'b00;
    step(2);

    // Owner stalls for three cycles while requester 1 waits.
    set_req(0, 3'd7, 7'h00, 32'hF0F0_1234, 32'hFF00_FF00);
    req_valid = 2'b01; step(1);
    rsp_ready = 2'b10;
    req_valid = 2'b10;
    step(3);
    rsp_ready = 2'b01; step(1);
    rsp_ready = 2'b11;
    req_valid = 2'b00;
    step(2);

    // Reset while holding a result, then a tie must go to requester 0.
    req_valid = 2'b10; step(1);
    rsp_ready = 2'b00; req_valid = 2'b00; step(2);
    rst = 1'b1; req_valid = 2'b11; step(1);
    rst = 1'b0; rsp_ready = 2'b11; step(4);
    req_valid = 2'b00; step(2);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      for (int i = 0; i < 2; i++) begin
        req_fun[i] = rand_fun();
        req_in1[i] = rand_operand();
        req_in2[i] = rand_operand();
      end
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0;

`ifdef ALU_SHARE_ARB_STATS_EN
    rst = 1'b1; step(1); rst = 1'b0;
    set_req(0, 3'd0, 7'h00, 32'd1, 32'd1);
    req_valid = 2'b01; rsp_ready = 2'b11;
    step(70000);
    req_valid = 2'b00;
    step(2);
    check("gnt_cnt0", 64'(gnt_cnt0), 64'(m_cnt0));
    check("gnt_cnt0_sat", 64'(gnt_cnt0), 64'hFFFF);
    check("gnt_cnt1", 64'(gnt_cnt1), 64'(m_cnt1));
`endif

    // Drain and confirm nothing is left outstanding.
    req_valid = 2'b00; rsp_ready = 2'b11;
    step(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("idle_at_end", 64'(state_dbg), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
